// File: rtl/fp_div_arbiter.sv
// Round-robin arbiter sharing one combinational 12-bit FP divider.
// Optional zero-divisor bypass enabled by defining FPDIV_DIVZERO_CHECK_EN.
module fp_div_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int REQ_ID_W = 2,
    parameter int DIV_LAT  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [12*NUM_REQ-1:0] req_a,
    input  logic [12*NUM_REQ-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [REQ_ID_W-1:0]   rsp_id,
    output logic [11:0]           rsp_data,
    output logic                  rsp_err,
    output logic [11:0]           div_in_1,
    output logic [11:0]           div_in_2,
    input  logic [11:0]           div_out,
    output logic                  busy
);
    localparam int CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIV_LAT - 1);
    localparam logic [REQ_ID_W-1:0] LAST_INIT = REQ_ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [11:0]         op_a;
    logic [11:0]         op_b;
    logic [CNT_W-1:0]    cnt;
    logic [REQ_ID_W-1:0] last_grant;
    logic [REQ_ID_W-1:0] grant;
    logic                found;
    logic                accept;
    logic                divzero;
    logic [11:0]         sel_a;
    logic [11:0]         sel_b;

    // Scan in reverse so the first valid after last_grant wins.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        grant = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == idx && req_valid[i]) begin
                    found = 1'b1;
                    grant = REQ_ID_W'(i);
                end
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == REQ_ID_W'(i)) begin
                sel_a = req_a[12*i +: 12];
                sel_b = req_b[12*i +: 12];
            end
        end
    end

    assign accept = (state == IDLE) && rst_n && found;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && (grant == REQ_ID_W'(i));
        end
    end

`ifdef FPDIV_DIVZERO_CHECK_EN
    assign divzero = ~|sel_b[10:0];
`else
    assign divzero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = divzero ? RESP : SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a       <= '0;
            op_b       <= '0;
            rsp_data   <= '0;
            rsp_id     <= '0;
            rsp_err    <= 1'b0;
            cnt        <= '0;
            last_grant <= LAST_INIT;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_a       <= sel_a;
                        op_b       <= sel_b;
                        rsp_id     <= grant;
                        last_grant <= grant;
                        cnt        <= CNT_INIT;
                        // Zero divisor answers immediately with signed infinity.
                        if (divzero) begin
                            rsp_data <= {sel_a[11] ^ sel_b[11], 5'h1F, 6'h00};
                            rsp_err  <= 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rsp_data <= div_out;
                        rsp_err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign div_in_1  = op_a;
    assign div_in_2  = op_b;

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Randomised + directed bench for fp_div_arbiter.
// Transaction-level timeline model predicts every output each cycle.
module tb_fp_div_arbiter;
    localparam int N   = 4;
    localparam int LAT = 2;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [12*N-1:0] req_a;
    logic [12*N-1:0] req_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [11:0]   rsp_data;
    logic          rsp_err;
    logic [11:0]   div_in_1;
    logic [11:0]   div_in_2;
    logic [11:0]   div_out;
    logic          busy;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: one outstanding transaction on a timeline.
    bit          known = 0;
    bit          outs  = 0;
    int          last  = N - 1;
    int          cyc   = 0;
    int          due   = 0;
    int          eid   = 0;
    int          acc_c = 0;
    int          first_rv = -1;
    logic [11:0] ea, eb, edata;
    logic        eerr;
    int          acc_q[$];
    int          acc_cq[$];
    bit          got = 0;
    logic [1:0]  got_id;
    logic [11:0] got_data;
    logic        got_err;
    bit          exp_dz;

    function automatic logic [11:0] fdiv(logic [11:0] a, logic [11:0] b);
        int ma, mb, q, e;
        ma = 64 + int'(a[5:0]);
        mb = 64 + int'(b[5:0]);
        q  = (ma * 256) / mb;
        e  = int'(a[10:6]) - int'(b[10:6]) + 15;
        if (q >= 256) begin
            q = q >> 2;
        end else begin
            q = q >> 1;
            e = e - 1;
        end
        return {a[11] ^ b[11], e[4:0], q[5:0]};
    endfunction

    function automatic int pick(logic [N-1:0] v, int lg);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (lg + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    assign div_out = fdiv(div_in_1, div_in_2);

    fp_div_arbiter #(
        .NUM_REQ (N),
        .REQ_ID_W(2),
        .DIV_LAT (LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .div_in_1 (div_in_1),
        .div_in_2 (div_in_2),
        .div_out  (div_out),
        .busy     (busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        int         g;
        logic       exp_rv;
        logic [3:0] exp_rdy;
        bit         dz;
        #1;
        g      = pick(req_valid, last);
        exp_rv = outs && (cyc >= due);
        if (known) begin
            exp_rdy = (rst_n && !outs && g >= 0) ? 4'(1 << g) : 4'h0;
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            check("busy", 32'(busy), 32'(outs));
            if (exp_rv) begin
                check("rsp_id", 32'(rsp_id), 32'(eid));
                check("rsp_data", 32'(rsp_data), 32'(edata));
                check("rsp_err", 32'(rsp_err), 32'(eerr));
            end
            if (outs) begin
                check("div_in_1", 32'(div_in_1), 32'(ea));
                check("div_in_2", 32'(div_in_2), 32'(eb));
            end
            if (rsp_valid && first_rv < 0) first_rv = cyc;
            if (exp_rv && rsp_ready && rst_n) begin
                got      = 1;
                got_id   = rsp_id;
                got_data = rsp_data;
                got_err  = rsp_err;
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            known = 1;
            outs  = 0;
            last  = N - 1;
        end else if (known) begin
            if (outs) begin
                if (exp_rv && rsp_ready) outs = 0;
            end else if (g >= 0) begin
                outs = 1;
                last = g;
                eid  = g;
                ea   = req_a[12*g +: 12];
                eb   = req_b[12*g +: 12];
`ifdef FPDIV_DIVZERO_CHECK_EN
                dz = (eb[10:0] == 11'h0);
`else
                dz = 0;
`endif
                edata    = dz ? {ea[11] ^ eb[11], 5'h1F, 6'h00} : fdiv(ea, eb);
                eerr     = dz;
                due      = cyc + 1 + (dz ? 0 : LAT);
                acc_c    = cyc;
                first_rv = -1;
                acc_q.push_back(g);
                acc_cq.push_back(cyc);
            end
        end
        cyc++;
        #1;
    endtask

    task automatic wait_rsp(string tag);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) step();
        if (!got) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1;
        for (int i = 0; i < 20 && outs; i++) step();
        if (outs) check("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst_n     = 0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 0;

        // Reset with every requester asking.
        req_valid = 4'hF;
        for (int i = 0; i < 3; i++) step();

        // Single request from requester 2.
        rst_n = 1;
        rsp_ready = 1;
        req_valid = 4'b0100;
        req_a[24 +: 12] = 12'h3E0;
        req_b[24 +: 12] = 12'h3C0;
        step();
        req_valid = '0;
        wait_rsp("t2");
        check("t2_id", 32'(got_id), 32'd2);
        check("t2_data", 32'(got_data), 32'h3E0);
        check("t2_err", 32'(got_err), 32'd0);
        check("t2_lat", 32'(first_rv - acc_c), 32'(LAT + 1));

        // Round-robin from reset.
        rst_n = 0;
        step();
        rst_n = 1;
        for (int i = 0; i < N; i++) begin
            req_a[12*i +: 12] = 12'(12'h300 + 12'(i));
            req_b[12*i +: 12] = 12'(12'h3C1 + 12'(i));
        end
        acc_q.delete();
        acc_cq.delete();
        req_valid = 4'hF;
        rsp_ready = 1;
        for (int i = 0; i < 20; i++) step();
        if (acc_q.size() < 5) begin
            check("t3_count", 32'(acc_q.size()), 32'd5);
        end else begin
            for (int k = 0; k < 5; k++) begin
                check("t3_grant", 32'(acc_q[k]), 32'(k % N));
                if (k > 0)
                    check("t3_gap", 32'(acc_cq[k] - acc_cq[k-1]), 32'(LAT + 2));
            end
        end

        // Backpressure in RESP.
        drain();
        req_valid = 4'b0010;
        rsp_ready = 0;
        step();
        req_valid = 4'hF;
        for (int i = 0; i < 10 && !(outs && cyc >= due); i++) step();
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_busy", 32'(busy), 32'd1);
            check("t4_rdy", 32'(req_ready), 32'd0);
        end
        req_valid = '0;
        rsp_ready = 1;
        step();
        step();
        check("t4_idle", 32'(busy), 32'd0);

        // Zero divisor.
        drain();
        req_valid = 4'b0001;
        req_a[0 +: 12] = 12'h3C0;
        req_b[0 +: 12] = 12'h800;
        step();
        req_valid = '0;
        wait_rsp("t5");
`ifdef FPDIV_DIVZERO_CHECK_EN
        exp_dz = 1;
`else
        exp_dz = 0;
`endif
        check("t5_data", 32'(got_data),
              exp_dz ? 32'hFC0 : 32'(fdiv(12'h3C0, 12'h800)));
        check("t5_err", 32'(got_err), 32'(exp_dz));
        check("t5_lat", 32'(first_rv - acc_c), exp_dz ? 32'd1 : 32'(LAT + 1));

        // Reset while settling.
        drain();
        req_valid = 4'hF;
        step();
        req_valid = '0;
        rst_n = 0;
        step();
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t6_quiet", 32'(rsp_valid), 32'd0);
        end
        acc_q.delete();
        req_valid = 4'hF;
        step();
        if (acc_q.size() == 0) check("t6_grant", 32'd99, 32'd0);
        else check("t6_grant", 32'(acc_q[0]), 32'd0);

        // Randomised traffic.
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            req_valid = N'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                req_a[12*i +: 12] = 12'($urandom);
                if ($urandom_range(0, 5) == 0)
                    req_b[12*i +: 12] = {1'($urandom), 11'h0};
                else
                    req_b[12*i +: 12] = 12'($urandom);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
